// File: rtl/spi_cmd_seq_if.sv
// Command-sequencer bundle: SPI byte-shifter side plus bus-arbiter request/done handshake.
// The slave modport is the sequencer's view; master is the view of whatever drives it.
interface spi_cmd_seq_if #(
   parameter int unsigned ADDR_WIDTH = 17
);
   logic                  frame_start_i;
   logic [7:0]            rx_byte_i;
   logic                  rx_valid_i;
   logic [7:0]            tx_byte_o;
   logic [ADDR_WIDTH-1:0] addr_o;
   logic [7:0]            data_o;
   logic                  rw_no;
   logic                  valid_o;
   logic                  done_i;
   logic [7:0]            rd_data_i;
   logic                  ready_no;
   logic                  err_o;

   modport slave (
      input  frame_start_i, rx_byte_i, rx_valid_i, done_i, rd_data_i,
      output tx_byte_o, addr_o, data_o, rw_no, valid_o, ready_no, err_o
   );

   modport master (
      output frame_start_i, rx_byte_i, rx_valid_i, done_i, rd_data_i,
      input  tx_byte_o, addr_o, data_o, rw_no, valid_o, ready_no, err_o
   );
endinterface

// File: rtl/spi_cmd_seq.sv
// Parses framed SPI command bytes into single bus requests (valid/done handshake),
// captures read data for the shifter and supports auto-incrementing block transfers.
module spi_cmd_seq #(
   parameter int unsigned ADDR_WIDTH = 17,
   parameter bit          STICKY_ERR = 1'b1
) (
   input  logic         clk_sys_i,
   input  logic         reset_ni,
   spi_cmd_seq_if.slave bus_io
);
   typedef enum logic [2:0] {
      StIdle, StCmd, StAhi, StAlo, StData, StReq, StDone, StDrain
   } state_e;

   localparam logic [2:0] OpWriteAt   = 3'b000;
   localparam logic [2:0] OpReadAt    = 3'b001;
   localparam logic [2:0] OpWriteNext = 3'b010;
   localparam logic [2:0] OpReadNext  = 3'b011;
   localparam logic [2:0] OpWriteSame = 3'b100;

   state_e                r_state, w_state, w_cur;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr;
   logic [7:0]            r_data, w_data;
   logic [7:0]            r_ahi, w_ahi;
   logic [7:0]            r_tx, w_tx;
   logic [2:0]            r_op, w_op;
   logic                  r_a16, w_a16;
   logic                  r_rw_n, w_rw_n;
   logic                  r_ready_n, w_ready_n;
   logic                  r_err, w_err;
   logic                  r_fs_pend, w_fs_pend;
   logic [7:0]            w_rx;

   assign w_rx = bus_io.rx_byte_i;

   always_ff @(posedge clk_sys_i) begin
      if (!reset_ni) begin
         r_state   <= StIdle;
         r_addr    <= '0;
         r_data    <= '0;
         r_ahi     <= '0;
         r_tx      <= '0;
         r_op      <= '0;
         r_a16     <= 1'b0;
         r_rw_n    <= 1'b1;
         r_ready_n <= 1'b1;
         r_err     <= 1'b0;
         r_fs_pend <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_addr    <= w_addr;
         r_data    <= w_data;
         r_ahi     <= w_ahi;
         r_tx      <= w_tx;
         r_op      <= w_op;
         r_a16     <= w_a16;
         r_rw_n    <= w_rw_n;
         r_ready_n <= w_ready_n;
         r_err     <= w_err;
         r_fs_pend <= w_fs_pend;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_cur     = r_state;
      w_addr    = r_addr;
      w_data    = r_data;
      w_ahi     = r_ahi;
      w_tx      = r_tx;
      w_op      = r_op;
      w_a16     = r_a16;
      w_rw_n    = r_rw_n;
      w_ready_n = r_ready_n;
      w_err     = STICKY_ERR ? r_err : 1'b0;
      w_fs_pend = r_fs_pend;

      if (bus_io.frame_start_i) begin
         w_ready_n = 1'b1;
         if (STICKY_ERR) w_err = 1'b0;
      end

      if (r_state == StReq) begin
         // A pending request is never aborted; a new frame only redirects where done lands.
         if (bus_io.frame_start_i) w_fs_pend = 1'b1;
         if (bus_io.rx_valid_i) w_err = 1'b1;
         if (bus_io.done_i) begin
            if (r_rw_n) w_tx = bus_io.rd_data_i;
            w_ready_n = 1'b0;
            w_state   = (r_fs_pend || bus_io.frame_start_i) ? StCmd : StDone;
            w_fs_pend = 1'b0;
         end
      end else begin
         w_cur   = bus_io.frame_start_i ? StCmd : r_state;
         w_state = w_cur;
         if (bus_io.rx_valid_i) begin
            case (w_cur)
               StCmd, StDone: begin
                  w_ready_n = 1'b1;
                  w_op      = w_rx[7:5];
                  w_a16     = w_rx[0];
                  case (w_rx[7:5])
                     OpWriteAt, OpReadAt:    w_state = StAhi;
                     OpWriteNext, OpWriteSame: w_state = StData;
                     OpReadNext: begin
                        w_addr  = r_addr + ADDR_WIDTH'(1);
                        w_rw_n  = 1'b1;
                        w_state = StReq;
                     end
                     default: w_state = StDrain;
                  endcase
               end
               StAhi: begin
                  w_ahi   = w_rx;
                  w_state = StAlo;
               end
               StAlo: begin
                  w_addr = ADDR_WIDTH'({r_a16, r_ahi, w_rx});
                  if (r_op == OpReadAt) begin
                     w_rw_n  = 1'b1;
                     w_state = StReq;
                  end else begin
                     w_state = StData;
                  end
               end
               StData: begin
                  w_data = w_rx;
                  w_rw_n = 1'b0;
                  if (r_op == OpWriteNext) w_addr = r_addr + ADDR_WIDTH'(1);
                  w_state = StReq;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus_io.tx_byte_o = r_tx;
   assign bus_io.addr_o    = r_addr;
   assign bus_io.data_o    = r_data;
   assign bus_io.rw_no     = r_rw_n;
   assign bus_io.valid_o   = (r_state == StReq);
   assign bus_io.ready_no  = r_ready_n;
   assign bus_io.err_o     = r_err;
endmodule

// File: tb/tb_spi_cmd_seq.sv
// Bench for spi_cmd_seq: directed command scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a byte-queue reference model.
module tb_spi_cmd_seq;
   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk_sys = ~clk_sys;

   spi_cmd_seq_if #(.ADDR_WIDTH(17)) bus ();

   spi_cmd_seq #(
      .ADDR_WIDTH(17),
      .STICKY_ERR(1'b1)
   ) dut (
      .clk_sys_i(clk_sys),
      .reset_ni (reset_n),
      .bus_io   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // Reference model: bytes of the current command collect in a queue until the opcode's length.
   logic [16:0] m_addr     = '0;
   logic [7:0]  m_data     = '0;
   logic [7:0]  m_tx       = '0;
   bit          m_rw       = 1'b1;
   bit          m_ready_n  = 1'b1;
   bit          m_err      = 1'b0;
   bit          m_pending  = 1'b0;
   bit          m_in_frame = 1'b0;
   bit          m_drain    = 1'b0;
   logic [7:0]  cq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int cmd_len(input logic [2:0] op);
      case (op)
         3'd0:    return 4;
         3'd1:    return 3;
         3'd2:    return 2;
         3'd3:    return 1;
         3'd4:    return 2;
         default: return 0;
      endcase
   endfunction

   task automatic model_step(input bit rst, input bit fs, input bit rxv, input logic [7:0] b,
                             input bit dn, input logic [7:0] rd);
      logic [2:0] op;
      if (!rst) begin
         m_addr = '0; m_data = '0; m_tx = '0; m_rw = 1'b1; m_ready_n = 1'b1; m_err = 1'b0;
         m_pending = 1'b0; m_in_frame = 1'b0; m_drain = 1'b0;
         cq.delete();
         return;
      end
      if (fs) begin
         m_ready_n = 1'b1;
         m_err     = 1'b0;
      end
      if (m_pending) begin
         if (rxv) m_err = 1'b1;
         if (dn) begin
            if (m_rw) m_tx = rd;
            m_ready_n  = 1'b0;
            m_pending  = 1'b0;
            m_in_frame = 1'b1;
         end
      end else begin
         if (fs) begin
            m_in_frame = 1'b1;
            m_drain    = 1'b0;
            cq.delete();
         end
         if (rxv && m_in_frame && !m_drain) begin
            if (cq.size() == 0) begin
               m_ready_n = 1'b1;
               if (b[7:5] > 3'd4) m_drain = 1'b1;
            end
            if (!m_drain) begin
               cq.push_back(b);
               op = cq[0][7:5];
               if (op <= 3'd1 && cq.size() == 3) m_addr = {cq[0][0], cq[1], cq[2]};
               if (cq.size() == cmd_len(op)) begin
                  case (op)
                     3'd0: begin m_data = cq[3]; m_rw = 1'b0; end
                     3'd1: m_rw = 1'b1;
                     3'd2: begin m_addr = m_addr + 17'd1; m_data = cq[1]; m_rw = 1'b0; end
                     3'd3: begin m_addr = m_addr + 17'd1; m_rw = 1'b1; end
                     default: begin m_data = cq[1]; m_rw = 1'b0; end
                  endcase
                  m_pending = 1'b1;
                  cq.delete();
               end
            end
         end
      end
   endtask

   always @(negedge clk_sys) begin
      if (chk_en) begin
         check("valid_o", 32'(bus.valid_o), 32'(m_pending));
         check("ready_no", 32'(bus.ready_no), 32'(m_ready_n));
         check("err_o", 32'(bus.err_o), 32'(m_err));
         check("tx_byte_o", 32'(bus.tx_byte_o), 32'(m_tx));
         check("addr_o", 32'(bus.addr_o), 32'(m_addr));
         check("data_o", 32'(bus.data_o), 32'(m_data));
         check("rw_no", 32'(bus.rw_no), 32'(m_rw));
      end
   end

   task automatic cycle(input bit rst, input bit fs, input bit rxv, input logic [7:0] b,
                        input bit dn, input logic [7:0] rd);
      reset_n           = rst;
      bus.frame_start_i = fs;
      bus.rx_valid_i    = rxv;
      bus.rx_byte_i     = b;
      bus.done_i        = dn;
      bus.rd_data_i     = rd;
      @(posedge clk_sys);
      model_step(rst, fs, rxv, b, dn, rd);
      @(negedge clk_sys);
      reset_n           = 1'b1;
      bus.frame_start_i = 1'b0;
      bus.rx_valid_i    = 1'b0;
      bus.done_i        = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, 1'b0, 1'b1, b, 1'b0, 8'h00);
   endtask

   task automatic fstart();
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic done_pulse(input logic [7:0] rd);
      cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, rd);
   endtask

   initial begin
      bus.frame_start_i = 1'b0;
      bus.rx_valid_i    = 1'b0;
      bus.rx_byte_i     = 8'h00;
      bus.done_i        = 1'b0;
      bus.rd_data_i     = 8'h00;
      @(negedge clk_sys);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      chk_en = 1'b1;
      check("reset valid_o", 32'(bus.valid_o), 32'd0);
      check("reset ready_no", 32'(bus.ready_no), 32'd1);
      check("reset rw_no", 32'(bus.rw_no), 32'd1);
      check("reset addr_o", 32'(bus.addr_o), 32'd0);

      // WRITE_AT 08000 <- 41
      fstart();
      send(8'h00); send(8'h80); send(8'h00);
      check("wr_at valid early", 32'(bus.valid_o), 32'd0);
      send(8'h41);
      check("wr_at valid", 32'(bus.valid_o), 32'd1);
      check("wr_at addr", 32'(bus.addr_o), 32'h08000);
      check("wr_at rw", 32'(bus.rw_no), 32'd0);
      check("wr_at data", 32'(bus.data_o), 32'h41);
      idle(3);
      done_pulse(8'h99);
      check("wr_at ready", 32'(bus.ready_no), 32'd0);
      check("wr_at valid drop", 32'(bus.valid_o), 32'd0);

      // READ_AT 1E812 -> 5A
      fstart();
      send(8'h21); send(8'hE8); send(8'h12);
      check("rd_at addr", 32'(bus.addr_o), 32'h1E812);
      check("rd_at rw", 32'(bus.rw_no), 32'd1);
      done_pulse(8'h5A);
      check("rd_at tx", 32'(bus.tx_byte_o), 32'h5A);
      check("rd_at ready", 32'(bus.ready_no), 32'd0);

      // READ_AT 1FFFF then READ_NEXT wraps to 00000
      fstart();
      send(8'h21); send(8'hFF); send(8'hFF);
      done_pulse(8'h11);
      send(8'h60);
      check("wrap valid", 32'(bus.valid_o), 32'd1);
      check("wrap addr", 32'(bus.addr_o), 32'h00000);
      done_pulse(8'h22);

      // WRITE_NEXT across frames after WRITE_AT 08000
      fstart();
      send(8'h00); send(8'h80); send(8'h00); send(8'h41);
      done_pulse(8'h00);
      fstart();
      send(8'h40); send(8'hAA);
      check("wnext1 addr", 32'(bus.addr_o), 32'h08001);
      done_pulse(8'h00);
      fstart();
      send(8'h40); send(8'hAA);
      check("wnext2 addr", 32'(bus.addr_o), 32'h08002);
      check("wnext2 data", 32'(bus.data_o), 32'hAA);
      done_pulse(8'h00);

      // Overrun and frame start while a request is held
      fstart();
      send(8'h60);
      idle(5);
      send(8'h77);
      check("ovr err", 32'(bus.err_o), 32'd1);
      check("ovr valid", 32'(bus.valid_o), 32'd1);
      check("ovr addr", 32'(bus.addr_o), 32'h08003);
      idle(10);
      fstart();
      check("fs_req valid", 32'(bus.valid_o), 32'd1);
      check("fs_req err clr", 32'(bus.err_o), 32'd0);
      idle(4);
      done_pulse(8'hC3);
      check("fs_req done valid", 32'(bus.valid_o), 32'd0);
      check("fs_req tx", 32'(bus.tx_byte_o), 32'hC3);
      send(8'h60);
      check("after fs cmd addr", 32'(bus.addr_o), 32'h08004);
      check("after fs ready", 32'(bus.ready_no), 32'd1);
      done_pulse(8'h00);

      // Illegal opcode drains; reset mid-request cancels
      fstart();
      send(8'hE0); send(8'h00); send(8'h80); send(8'h00); send(8'h41);
      check("drain valid", 32'(bus.valid_o), 32'd0);
      fstart();
      send(8'h00); send(8'h12); send(8'h34); send(8'h56);
      check("pre-rst valid", 32'(bus.valid_o), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      check("rst valid", 32'(bus.valid_o), 32'd0);
      check("rst ready", 32'(bus.ready_no), 32'd1);
      check("rst addr", 32'(bus.addr_o), 32'd0);

      for (int i = 0; i < 4000; i++) begin
         automatic bit         r_rst;
         automatic bit         r_fs;
         automatic bit         r_rxv;
         automatic bit         r_dn;
         automatic logic [7:0] r_b;
         r_rst = ($urandom_range(0, 599) != 0);
         r_fs  = ($urandom_range(0, 29) == 0);
         r_rxv = ($urandom_range(0, 2) == 0);
         r_b   = 8'($urandom);
         if ($urandom_range(0, 9) < 8) r_b[7:5] = 3'($urandom_range(0, 4));
         r_dn  = m_pending ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
         cycle(r_rst, r_fs, r_rxv, r_b, r_dn, 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
